// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input gate unit: walks {a,b} through 00..11,
// compares the packed gate outputs against a golden model and reports a sticky fail summary.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; results from the last run held
// ST_DRIVE | current vector on a/b, first cycle
// ST_WAIT  | settle time, SETTLE cycles counted down (skipped if 0)
// ST_CHECK | sample y, accumulate mismatches, advance vector
// ST_DONE  | one-cycle done pulse, pass valid
module gate_bist_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] vec;
    logic [3:0] wait_cnt;
    logic [6:0] y_exp;
    logic [6:0] mismatch;
    logic [6:0] mask_nxt;

    assign a    = vec[1];
    assign b    = vec[0];
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Golden gate model, bit order matches the packed y bus
    assign y_exp    = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    assign mismatch = y ^ y_exp;
    assign mask_nxt = fail_mask | mismatch;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
            ST_WAIT:  if (wait_cnt == 4'd0) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = (vec == 2'd3) ? ST_DONE : ST_DRIVE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec              <= 2'd0;
            wait_cnt         <= 4'd0;
            pass             <= 1'b0;
            fail_mask        <= 7'd0;
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec              <= 2'd0;
                        pass             <= 1'b0;
                        fail_mask        <= 7'd0;
                        first_fail_vec   <= 2'd0;
                        first_fail_valid <= 1'b0;
                    end
                end
                ST_DRIVE: wait_cnt <= WAIT_LOAD;
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                ST_CHECK: begin
                    fail_mask <= mask_nxt;
                    if ((mismatch != 7'd0) && !first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    // pass is resolved here so it is already valid while done is high
                    if (vec != 2'd3) vec  <= vec + 2'd1;
                    else             pass <= (mask_nxt == 7'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: stimulus pushes expected run results, monitors
// pop and compare on each done pulse. Two instances cover SETTLE=1 and SETTLE=0.
module tb_gate_bist_ctrl;

    typedef struct {
        int         due;
        logic       ps;
        logic [6:0] m;
        logic [1:0] fv;
        logic       fva;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start0;
    logic       a1, b1, a0, b0;
    logic [6:0] y1, y0;
    logic       busy1, done1, pass1, ffva1;
    logic       busy0, done0, pass0, ffva0;
    logic [6:0] mask1, mask0;
    logic [1:0] ffv1, ffv0;
    int         fault;
    int         edge_cnt = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       q1[$];
    exp_t       q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    gate_bist_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1),
        .first_fail_vec(ffv1), .first_fail_valid(ffva1)
    );

    gate_bist_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0),
        .first_fail_vec(ffv0), .first_fail_valid(ffva0)
    );

    // Gate unit model with selectable faults
    function automatic logic [6:0] gate_model(input logic ga, input logic gb, input int mode);
        logic [6:0] g;
        g = {~ga, ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
        case (mode)
            1: g[4] = 1'b0;
            2: begin g[6] = ~g[6]; g[0] = 1'b1; end
            3: if (ga && gb) g[3] = ~g[3];
            default: ;
        endcase
        return g;
    endfunction

    assign y1 = gate_model(a1, b1, fault);
    assign y0 = gate_model(a0, b0, fault);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1 unexpected done at edge %0d", edge_cnt);
            end else begin
                e = q1.pop_front();
                chk("dut1 done_edge", edge_cnt, e.due);
                chk("dut1 pass", pass1, e.ps);
                chk("dut1 fail_mask", mask1, e.m);
                chk("dut1 first_fail_vec", ffv1, e.fv);
                chk("dut1 first_fail_valid", ffva1, e.fva);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0 unexpected done at edge %0d", edge_cnt);
            end else begin
                e = q0.pop_front();
                chk("dut0 done_edge", edge_cnt, e.due);
                chk("dut0 pass", pass0, e.ps);
                chk("dut0 fail_mask", mask0, e.m);
                chk("dut0 first_fail_vec", ffv0, e.fv);
                chk("dut0 first_fail_valid", ffva0, e.fva);
            end
        end
    end

    // Pulse start on dut1 for one edge; done expected 12 edges after acceptance
    task automatic issue1(input int mode, input logic ps, input logic [6:0] m,
                          input logic [1:0] fv, input logic fva);
        @(negedge clk);
        fault  = mode;
        start1 = 1'b1;
        q1.push_back('{due: edge_cnt + 1 + 12, ps: ps, m: m, fv: fv, fva: fva});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic issue0(input int mode, input logic ps, input logic [6:0] m,
                          input logic [1:0] fv, input logic fva);
        @(negedge clk);
        fault  = mode;
        start0 = 1'b1;
        q0.push_back('{due: edge_cnt + 1 + 8, ps: ps, m: m, fv: fv, fva: fva});
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 80; i++) begin
            if (q1.size() == 0 && q0.size() == 0) break;
            @(negedge clk);
        end
        if (q1.size() != 0 || q0.size() != 0) begin
            total++; bad++;
            $display("FAIL %s timeout: pending %0d/%0d expected 0", name, q1.size(), q0.size());
            q1.delete();
            q0.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, " busy"}, busy1, 1'b0);
        chk({tag, " done"}, done1, 1'b0);
        chk({tag, " pass"}, pass1, 1'b0);
        chk({tag, " fail_mask"}, mask1, 7'd0);
        chk({tag, " first_fail_vec"}, ffv1, 2'd0);
        chk({tag, " first_fail_valid"}, ffva1, 1'b0);
        chk({tag, " ab"}, {a1, b1}, 2'b00);
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        fault  = 0;
        repeat (3) @(negedge clk);
        chk_reset1("reset dut1");
        chk("reset dut0 busy", busy0, 1'b0);
        chk("reset dut0 fail_mask", mask0, 7'd0);
        rst = 1'b0;

        // Clean run, also checks the vector order while each vector is in DRIVE
        issue1(0, 1'b1, 7'b0000000, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("drive busy", busy1, 1'b1);
            chk("drive ab", {a1, b1}, k);
            repeat (3) @(negedge clk);
        end
        wait_drain("clean run");
        repeat (4) @(negedge clk);
        chk("hold pass", pass1, 1'b1);
        chk("hold busy", busy1, 1'b0);

        issue1(1, 1'b0, 7'b0010000, 2'b01, 1'b1);
        wait_drain("xor stuck0");
        issue1(2, 1'b0, 7'b1000001, 2'b00, 1'b1);
        wait_drain("not inv and stuck1");
        issue1(3, 1'b0, 7'b0001000, 2'b11, 1'b1);
        wait_drain("nor at 11");
        repeat (5) @(negedge clk);
        chk("hold fail_mask", mask1, 7'b0001000);
        chk("hold first_fail_vec", ffv1, 2'b11);

        // start held high: second run accepted two edges after done
        @(negedge clk);
        fault  = 0;
        start1 = 1'b1;
        q1.push_back('{due: edge_cnt + 13, ps: 1'b1, m: 7'd0, fv: 2'd0, fva: 1'b0});
        q1.push_back('{due: edge_cnt + 27, ps: 1'b1, m: 7'd0, fv: 2'd0, fva: 1'b0});
        repeat (15) @(negedge clk);
        start1 = 1'b0;
        wait_drain("held start");

        // start pulses during DRIVE and CHECK must be ignored
        issue1(1, 1'b0, 7'b0010000, 2'b01, 1'b1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_drain("busy start ignored");
        repeat (20) @(negedge clk);

        // Reset in WAIT of vector 10, then a clean run
        issue1(2, 1'b0, 7'b1000001, 2'b00, 1'b1);
        repeat (7) @(negedge clk);
        chk("pre-reset busy", busy1, 1'b1);
        chk("pre-reset ab", {a1, b1}, 2'b10);
        rst = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        chk_reset1("midrun reset");
        rst = 1'b0;
        start1 = 1'b0;
        q1.delete();
        issue1(0, 1'b1, 7'b0000000, 2'b00, 1'b0);
        wait_drain("post-reset run");

        // SETTLE = 0 instance
        issue0(0, 1'b1, 7'b0000000, 2'b00, 1'b0);
        wait_drain("settle0 clean");
        issue0(1, 1'b0, 7'b0010000, 2'b01, 1'b1);
        wait_drain("settle0 xor stuck0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
